mem_channel_responder: RTL

Multi-channel memory responder that sits on the memory side of the memory-access controller. It serves the controller's mem_read_* and mem_write_* channel handshakes from an internal word array, with parameterised fixed latency. It is used as the data memory and the program memory model in the GPU (WRITE_ENABLE=0 for program memory). A backdoor load port initialises contents.

---
 rtl/mem_channel_responder_if.sv | 30 +++
 rtl/mem_channel_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_channel_responder_if.sv
// Per-channel read/write handshake bundle between the memory controller (master)
// and a memory model (slave).
interface mem_channel_responder_if #(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned NUM_CHANNELS = 4
);
    logic [NUM_CHANNELS-1:0]                mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
    logic [NUM_CHANNELS-1:0]                mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
    logic [NUM_CHANNELS-1:0]                mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
    logic [NUM_CHANNELS-1:0]                mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/mem_channel_responder.sv
// Multi-channel fixed-latency memory model: per-channel read/write FSMs with a
// four-phase valid/ready handshake over a shared word array, plus a backdoor load port.
module mem_channel_responder #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 2,
    parameter int unsigned WRITE_ENABLE  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    mem_channel_responder_if.slave    mem,
    input  logic                      load_valid,
    input  logic [ADDR_BITS-1:0]      load_address,
    input  logic [DATA_BITS-1:0]      load_data
);
    localparam int unsigned DEPTH    = 2 ** ADDR_BITS;
    localparam int unsigned MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_BITS = (MAX_LAT > 2) ? $clog2(MAX_LAT - 1) : 1;
    localparam logic [CNT_BITS-1:0] RD_CNT_INIT = CNT_BITS'((READ_LATENCY > 2) ? READ_LATENCY - 2 : 0);
    localparam logic [CNT_BITS-1:0] WR_CNT_INIT = CNT_BITS'((WRITE_LATENCY > 2) ? WRITE_LATENCY - 2 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [DATA_BITS-1:0] mem_array [DEPTH];

    state_t              rd_state [NUM_CHANNELS];
    logic [CNT_BITS-1:0] rd_cnt   [NUM_CHANNELS];
    state_t              wr_state [NUM_CHANNELS];
    logic [CNT_BITS-1:0] wr_cnt   [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] rd_addr_q;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rd_data_q;
    logic [NUM_CHANNELS-1:0]                rd_ready_q;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] wr_addr_q;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wr_data_q;
    logic [NUM_CHANNELS-1:0]                wr_ready_q;

    logic [NUM_CHANNELS-1:0]                rd_fire;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] rd_fire_addr;
    logic [NUM_CHANNELS-1:0]                wr_fire;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] wr_fire_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wr_fire_data;

    assign mem.mem_read_ready  = rd_ready_q;
    assign mem.mem_read_data   = rd_data_q;
    assign mem.mem_write_ready = wr_ready_q;

    // "fire" marks the edge that enters DONE; with latency 1 that is the accept edge,
    // so the address/data come straight from the inputs instead of the capture regs.
    always_comb begin
        rd_fire      = '0;
        rd_fire_addr = '0;
        wr_fire      = '0;
        wr_fire_addr = '0;
        wr_fire_data = '0;
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (rd_state[ch] == S_IDLE) begin
                rd_fire_addr[ch] = mem.mem_read_address[ch];
            end else begin
                rd_fire_addr[ch] = rd_addr_q[ch];
            end
            rd_fire[ch] = mem.mem_read_valid[ch] &&
                          ((rd_state[ch] == S_IDLE && READ_LATENCY == 1) ||
                           (rd_state[ch] == S_WAIT && rd_cnt[ch] == '0));

            if (wr_state[ch] == S_IDLE) begin
                wr_fire_addr[ch] = mem.mem_write_address[ch];
                wr_fire_data[ch] = mem.mem_write_data[ch];
            end else begin
                wr_fire_addr[ch] = wr_addr_q[ch];
                wr_fire_data[ch] = wr_data_q[ch];
            end
            wr_fire[ch] = reset && (WRITE_ENABLE != 0) && mem.mem_write_valid[ch] &&
                          ((wr_state[ch] == S_IDLE && WRITE_LATENCY == 1) ||
                           (wr_state[ch] == S_WAIT && wr_cnt[ch] == '0));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                rd_state[ch] <= S_IDLE;
                rd_cnt[ch]   <= '0;
                wr_state[ch] <= S_IDLE;
                wr_cnt[ch]   <= '0;
            end
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_ready_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_ready_q <= '0;
        end else begin
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (rd_state[ch])
                    S_IDLE: begin
                        if (mem.mem_read_valid[ch]) begin
                            rd_addr_q[ch] <= mem.mem_read_address[ch];
                            rd_cnt[ch]    <= RD_CNT_INIT;
                            rd_state[ch]  <= rd_fire[ch] ? S_DONE : S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (!mem.mem_read_valid[ch]) begin
                            rd_state[ch] <= S_IDLE;
                        end else if (rd_fire[ch]) begin
                            rd_state[ch] <= S_DONE;
                        end else begin
                            rd_cnt[ch] <= rd_cnt[ch] - CNT_BITS'(1);
                        end
                    end
                    S_DONE: begin
                        if (!mem.mem_read_valid[ch]) begin
                            rd_state[ch]   <= S_IDLE;
                            rd_ready_q[ch] <= 1'b0;
                        end
                    end
                    default: rd_state[ch] <= S_IDLE;
                endcase
                if (rd_fire[ch]) begin
                    rd_ready_q[ch] <= 1'b1;
                    rd_data_q[ch]  <= mem_array[rd_fire_addr[ch]];
                end

                case (wr_state[ch])
                    S_IDLE: begin
                        if (WRITE_ENABLE != 0 && mem.mem_write_valid[ch]) begin
                            wr_addr_q[ch] <= mem.mem_write_address[ch];
                            wr_data_q[ch] <= mem.mem_write_data[ch];
                            wr_cnt[ch]    <= WR_CNT_INIT;
                            wr_state[ch]  <= wr_fire[ch] ? S_DONE : S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (!mem.mem_write_valid[ch]) begin
                            wr_state[ch] <= S_IDLE;
                        end else if (wr_fire[ch]) begin
                            wr_state[ch] <= S_DONE;
                        end else begin
                            wr_cnt[ch] <= wr_cnt[ch] - CNT_BITS'(1);
                        end
                    end
                    S_DONE: begin
                        if (!mem.mem_write_valid[ch]) begin
                            wr_state[ch]   <= S_IDLE;
                            wr_ready_q[ch] <= 1'b0;
                        end
                    end
                    default: wr_state[ch] <= S_IDLE;
                endcase
                if (wr_fire[ch]) begin
                    wr_ready_q[ch] <= 1'b1;
                end
            end
        end
    end

    // Later assignments win on the same edge: load first, then channels in ascending order.
    always_ff @(posedge clk) begin
        if (load_valid) begin
            mem_array[load_address] <= load_data;
        end
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (wr_fire[ch]) begin
                mem_array[wr_fire_addr[ch]] <= wr_fire_data[ch];
            end
        end
    end
endmodule
